// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types for the EX-stage forwarding/hazard controller: operand-select encodings,
// shadow-pipeline slot record and controller state.
package fwd_hazard_ctrl_pkg;

    // Slots store the destination zero-extended to this width so the record stays fixed.
    localparam int SLOT_DST_W = 8;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic                  valid;
        logic [SLOT_DST_W-1:0] dst;
        logic                  wen;
        logic                  is_load;
    } slot_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    function automatic slot_t bubble_slot();
        return '0;
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Decoder-facing bundle of the forwarding/hazard controller; master = decoder, slave = controller.
interface fwd_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_rs_used;
    logic                  id_rt_used;
    logic [REG_ADDR_W-1:0] id_dst;
    logic                  id_wen;
    logic                  id_is_load;
    logic                  flush;
    logic                  stall;
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_dst, id_wen, id_is_load, flush,
        input  stall, fwd_a, fwd_b, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_dst, id_wen, id_is_load, flush,
        output stall, fwd_a, fwd_b, stall_count
    );
endinterface

// File: rtl/fwd_hazard_ctrl_fwd_src_sel.sv
// Per-operand forwarding select: picks the most recent in-flight producer of one source register.
module fwd_src_sel
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] i_src,
    input  logic                  i_used,
    input  slot_t                 i_ex,
    input  slot_t                 i_mem,
    output fwd_sel_t              o_sel,
    output logic                  o_load_match
);

    logic [SLOT_DST_W-1:0] w_src_ext;
    logic                  w_src_live;
    logic                  w_ex_match;
    logic                  w_mem_match;

    // Register 0 is hardwired, so it never takes a forwarded value.
    assign w_src_ext   = SLOT_DST_W'(i_src);
    assign w_src_live  = i_used && (i_src != '0);
    assign w_ex_match  = w_src_live && i_ex.valid  && i_ex.wen  && (i_ex.dst  == w_src_ext);
    assign w_mem_match = w_src_live && i_mem.valid && i_mem.wen && (i_mem.dst == w_src_ext);

    always_comb begin
        o_sel = FWD_REG;
        if (w_ex_match) begin
            o_sel = FWD_EXMEM;
        end else if (w_mem_match) begin
            o_sel = FWD_MEMWB;
        end
    end

    assign o_load_match = w_ex_match && i_ex.is_load;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller beside the ID/EX register.
// Build macro FWD_HAZARD_FORWARD_EN enables operand forwarding; without it every dependency stalls.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    fwd_hazard_ctrl_if.slave   bus
);

    slot_t            r_ex;
    slot_t            r_mem;
    state_t           r_state;
    logic [CNT_W-1:0] r_count;

    fwd_sel_t w_sel_a;
    fwd_sel_t w_sel_b;
    logic     w_ld_a;
    logic     w_ld_b;
    logic     w_hazard;
    logic     w_stall;
    logic     w_ex_load;

    fwd_src_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel_a (
        .i_src        (bus.id_rs),
        .i_used       (bus.id_rs_used),
        .i_ex         (r_ex),
        .i_mem        (r_mem),
        .o_sel        (w_sel_a),
        .o_load_match (w_ld_a)
    );

    fwd_src_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel_b (
        .i_src        (bus.id_rt),
        .i_used       (bus.id_rt_used),
        .i_ex         (r_ex),
        .i_mem        (r_mem),
        .o_sel        (w_sel_b),
        .o_load_match (w_ld_b)
    );

`ifdef FWD_HAZARD_FORWARD_EN
    assign w_hazard = w_ld_a || w_ld_b;
`else
    // Load matches are a subset of slot matches; any in-flight producer blocks the consumer.
    assign w_hazard = (w_sel_a != FWD_REG) || (w_sel_b != FWD_REG) || w_ld_a || w_ld_b;
`endif

    assign w_stall   = bus.id_valid && !bus.flush && w_hazard;
    assign w_ex_load = bus.id_valid && !bus.flush && !w_stall;
    assign bus.stall = w_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex  <= bubble_slot();
            r_mem <= bubble_slot();
        end else begin
            r_mem <= r_ex;
            if (w_ex_load) begin
                r_ex <= '{valid:   1'b1,
                          dst:     SLOT_DST_W'(bus.id_dst),
                          wen:     bus.id_wen,
                          is_load: bus.id_is_load};
            end else begin
                r_ex <= bubble_slot();
            end
        end
    end

`ifdef FWD_HAZARD_FORWARD_EN
    logic [1:0] r_fwd_a;
    logic [1:0] r_fwd_b;

    always_ff @(posedge clk) begin
        if (reset || !w_ex_load) begin
            r_fwd_a <= FWD_REG;
            r_fwd_b <= FWD_REG;
        end else begin
            r_fwd_a <= w_sel_a;
            r_fwd_b <= w_sel_b;
        end
    end

    assign bus.fwd_a = r_fwd_a;
    assign bus.fwd_b = r_fwd_b;
`else
    assign bus.fwd_a = FWD_REG;
    assign bus.fwd_b = FWD_REG;
`endif

    // The count tracks cycles spent in STALL, saturating instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_count <= '0;
        end else begin
            r_state <= w_stall ? STALL : RUN;
            if ((r_state == STALL) && (r_count != '1)) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign bus.stall_count = r_count;

endmodule
